controller_tanh: RTL and testbench
==================================

# controller_tanh

Sequencing FSM for the fixed-point tanh(x) Taylor-series datapath (`datapath_tanh`). It accepts a start request and drives that datapath's load, select, counter and add/subtract controls through one initialisation cycle and eight three-cycle term iterations. It signals completion with a one-cycle `done` pulse while the result is valid on the datapath's `yBus`. It sits beside the datapath under the tanh top level.

## Interface
- Parameters: none. The term count of 8 is fixed by the datapath's 3-bit coefficient counter and its `Cout` flag.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a computation; sampled only in IDLE.
- odd_even  in  1  datapath coefficient-address LSB.
- Cout  in  1  datapath last-coefficient flag (address == 7).
- initz, Cen  out  1 each  counter clear and counter increment.
- Ld_term, Ld_expr, Ld_sqr  out  1 each  register loads.
- sel_x, sel_rom, sel_sqr, sel_term, sel_a, sel_pr  out  1 each  datapath mux selects.
- subsel  out  1  1 = `expr` − `term`, 0 = `expr` + `term`.
- busy  out  1  high from INIT through the last ADD.
- done  out  1  one-cycle completion pulse.

## Operation
- Moore FSM. All outputs decode from the state register only. Any output not listed for a state is 0.
- IDLE: no outputs asserted. Transitions:
  - start = 1 → INIT.
  - otherwise stay in IDLE.
- INIT: sel_x, Ld_term, Ld_expr, Ld_sqr, initz, busy.
  - Datapath effect: term = x, expr = x, sqr = x², address = 0.
  - Next state: MUL_SQR.
- MUL_SQR: sel_sqr, sel_term, sel_pr, Ld_term, busy.
  - Datapath effect: term = term·x².
  - Next state: MUL_ROM.
- MUL_ROM: sel_rom, sel_term, sel_pr, Ld_term, busy.
  - Datapath effect: term = term·ROM[address].
  - Next state: ADD.
- ADD: sel_a, Ld_expr, Cen, busy, subsel = ~odd_even.
  - Datapath effect: expr updated with the signed term; address increments.
  - Next state: DONE if Cout = 1, else MUL_SQR.
- DONE: done. Next state: IDLE unconditionally.
- Sign pattern: address 0 subtracts (the x³ term). Across the eight ADDs, subsel must follow 1,0,1,0,1,0,1,0.
- Counter wrap: the final ADD also pulses Cen, so address wraps 7→0. This is harmless; the next INIT clears it anyway.
- Ignored inputs: start is ignored in every state except IDLE. odd_even and Cout are ignored outside ADD.
- Held start: if start stays high through DONE, the FSM passes through IDLE and re-enters INIT one cycle later. There is no DONE→INIT shortcut.
- State encoding: one-hot or binary, implementer's choice. Unreachable codes must recover to IDLE.

## Timing
- Reset: async assertion forces IDLE immediately. Every output is 0 while rst is high and in the first cycle after release, including busy and done.
- Reset mid-computation: the controller goes straight to IDLE with no done pulse. The datapath is reset by the same rst.
- Latency, with start sampled high in IDLE at edge 0:
  - INIT occupies cycle 1.
  - Iterations occupy cycles 2–25 (8 × 3).
  - DONE occupies cycle 26.
- Result timing: `yBus` holds the final sum from edge 26 onward, through DONE and until the next INIT.
- Throughput: one result per 27 cycles with start held high.

## Structure
- Shared header/package `tanh_pkg`: state encodings, `TANH_TERMS = 8`, `TANH_ITER_CYCLES = 3`.
- No sub-module: a single state register plus an output decode.
- `tanh_top` instantiates `controller_tanh` and `datapath_tanh` and wires ports one-to-one by name.

## Test plan
- Reset value check: assert rst mid-stream, then release. Required: all outputs 0 and state IDLE; start asserted 1 cycle later gives busy = 1 in the following cycle.
- Zero input: x = 16'h0000, pulse start. Required: done exactly 26 cycles after the start edge and yBus = 16'h0000.
- Nominal input: x = 16'h4000 (0.5, Q1.15). Required: yBus within ±8 LSB of 16'h3B27 (tanh 0.5 = 0.4621) at done. Exactly eight ADD cycles, with subsel sequence 1,0,1,0,1,0,1,0.
- INIT decode and mutual exclusion: in the INIT cycle, sel_x, Ld_term, Ld_expr, Ld_sqr and initz = 1 and all other outputs 0. In every cycle, at most one of sel_x/sel_rom/sel_sqr is high.
- Start during busy: pulse start again at cycle 10 of a run. Required: ignored; a single done at cycle 26 with an unchanged result.
- Reset mid-run: assert rst at cycle 12. Required: busy drops immediately, no done pulse. A fresh start afterwards completes normally in 26 cycles.

Source files
------------

// File: rtl/tanh_pkg.sv
// Shared definitions for the tanh(x) Taylor-series controller and datapath.
package tanh_pkg;

  // Number of series terms, set by the datapath's 3-bit coefficient counter.
  localparam int TANH_TERMS       = 8;
  // Cycles per term iteration: multiply by x^2, multiply by ROM coefficient, accumulate.
  localparam int TANH_ITER_CYCLES = 3;

  // Controller states. Binary encoding; codes 6 and 7 are unreachable.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_MUL_SQR = 3'd2,
    S_MUL_ROM = 3'd3,
    S_ADD     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/controller_tanh.sv
// Sequencing FSM for the tanh(x) datapath: one INIT cycle, eight
// MUL_SQR/MUL_ROM/ADD iterations, then a one-cycle DONE pulse.
module controller_tanh
  import tanh_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic odd_even,
  input  logic Cout,
  output logic initz,
  output logic Cen,
  output logic Ld_term,
  output logic Ld_expr,
  output logic Ld_sqr,
  output logic sel_x,
  output logic sel_rom,
  output logic sel_sqr,
  output logic sel_term,
  output logic sel_a,
  output logic sel_pr,
  output logic subsel,
  output logic busy,
  output logic done
);

  state_t state_q;
  state_t state_d;

  // State register; asynchronous reset forces IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and output decode from the current state.
  always_comb begin
    state_d  = S_IDLE;
    initz    = 1'b0;
    Cen      = 1'b0;
    Ld_term  = 1'b0;
    Ld_expr  = 1'b0;
    Ld_sqr   = 1'b0;
    sel_x    = 1'b0;
    sel_rom  = 1'b0;
    sel_sqr  = 1'b0;
    sel_term = 1'b0;
    sel_a    = 1'b0;
    sel_pr   = 1'b0;
    subsel   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = start ? S_INIT : S_IDLE;
      end
      S_INIT: begin
        // term = x, expr = x, sqr = x^2, coefficient address cleared.
        sel_x   = 1'b1;
        Ld_term = 1'b1;
        Ld_expr = 1'b1;
        Ld_sqr  = 1'b1;
        initz   = 1'b1;
        busy    = 1'b1;
        state_d = S_MUL_SQR;
      end
      S_MUL_SQR: begin
        // term = term * x^2
        sel_sqr  = 1'b1;
        sel_term = 1'b1;
        sel_pr   = 1'b1;
        Ld_term  = 1'b1;
        busy     = 1'b1;
        state_d  = S_MUL_ROM;
      end
      S_MUL_ROM: begin
        // term = term * ROM[address]
        sel_rom  = 1'b1;
        sel_term = 1'b1;
        sel_pr   = 1'b1;
        Ld_term  = 1'b1;
        busy     = 1'b1;
        state_d  = S_ADD;
      end
      S_ADD: begin
        // Even addresses subtract (x^3, x^7, ...), odd addresses add.
        // The final increment wraps the address to 0; INIT clears it anyway.
        sel_a   = 1'b1;
        Ld_expr = 1'b1;
        Cen     = 1'b1;
        busy    = 1'b1;
        subsel  = ~odd_even;
        state_d = Cout ? S_DONE : S_MUL_SQR;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_controller_tanh.sv
// Scoreboard bench for controller_tanh: a small coefficient-counter model
// feeds odd_even/Cout back, and the expected output word for every cycle of a
// run is queued when start is driven and compared each falling edge.
module tb_controller_tanh;
  import tanh_pkg::*;

  logic clk;
  logic rst;
  logic start;
  logic odd_even;
  logic Cout;
  logic initz, Cen, Ld_term, Ld_expr, Ld_sqr;
  logic sel_x, sel_rom, sel_sqr, sel_term, sel_a, sel_pr;
  logic subsel, busy, done;

  int n_compared;
  int n_mismatched;
  int done_cnt;
  logic [2:0] addr_q;
  logic [13:0] exp_q[$];

  // Output word bit positions.
  localparam logic [13:0] O_INITZ = 14'h2000;
  localparam logic [13:0] O_CEN   = 14'h1000;
  localparam logic [13:0] O_LDT   = 14'h0800;
  localparam logic [13:0] O_LDE   = 14'h0400;
  localparam logic [13:0] O_LDS   = 14'h0200;
  localparam logic [13:0] O_SELX  = 14'h0100;
  localparam logic [13:0] O_SELR  = 14'h0080;
  localparam logic [13:0] O_SELS  = 14'h0040;
  localparam logic [13:0] O_SELT  = 14'h0020;
  localparam logic [13:0] O_SELA  = 14'h0010;
  localparam logic [13:0] O_SELP  = 14'h0008;
  localparam logic [13:0] O_SUB   = 14'h0004;
  localparam logic [13:0] O_BUSY  = 14'h0002;
  localparam logic [13:0] O_DONE  = 14'h0001;

  localparam logic [13:0] W_INIT = O_SELX | O_LDT | O_LDE | O_LDS | O_INITZ | O_BUSY;
  localparam logic [13:0] W_MSQR = O_SELS | O_SELT | O_SELP | O_LDT | O_BUSY;
  localparam logic [13:0] W_MROM = O_SELR | O_SELT | O_SELP | O_LDT | O_BUSY;
  localparam logic [13:0] W_ADD  = O_SELA | O_LDE | O_CEN | O_BUSY;
  localparam logic [13:0] W_DONE = O_DONE;

  controller_tanh dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .odd_even (odd_even),
    .Cout     (Cout),
    .initz    (initz),
    .Cen      (Cen),
    .Ld_term  (Ld_term),
    .Ld_expr  (Ld_expr),
    .Ld_sqr   (Ld_sqr),
    .sel_x    (sel_x),
    .sel_rom  (sel_rom),
    .sel_sqr  (sel_sqr),
    .sel_term (sel_term),
    .sel_a    (sel_a),
    .sel_pr   (sel_pr),
    .subsel   (subsel),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath coefficient address counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) addr_q <= 3'd0;
    else if (initz) addr_q <= 3'd0;
    else if (Cen) addr_q <= addr_q + 3'd1;
  end
  assign odd_even = addr_q[0];
  assign Cout     = (addr_q == 3'd7);

  function automatic logic [13:0] obs_word();
    return {initz, Cen, Ld_term, Ld_expr, Ld_sqr, sel_x, sel_rom, sel_sqr,
            sel_term, sel_a, sel_pr, subsel, busy, done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Queue the 26 per-cycle output words of one complete computation.
  task automatic push_run();
    exp_q.push_back(W_INIT);
    for (int k = 0; k < TANH_TERMS; k++) begin
      exp_q.push_back(W_MSQR);
      exp_q.push_back(W_MROM);
      exp_q.push_back(W_ADD | (((k % 2) == 0) ? O_SUB : 14'h0));
    end
    exp_q.push_back(W_DONE);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Pulse start for one cycle while the controller is idle.
  task automatic start_run();
    @(negedge clk);
    #1;
    start = 1'b1;
    push_run();
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  // Per-cycle scoreboard compare; idle cycles expect all outputs low.
  always @(negedge clk) begin
    logic [13:0] want;
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 14'h0;
    chk("outputs", 32'(obs_word()), 32'(want));
    chk("mux_excl", 32'($countones({sel_x, sel_rom, sel_sqr}) <= 1), 32'd1);
    if (done) begin
      done_cnt++;
      $display("run %0d complete at t=%0t", done_cnt, $time);
    end
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    done_cnt     = 0;
    rst   = 1'b1;
    start = 1'b0;
    wait_cycles(3);
    chk("reset_outs", 32'(obs_word()), 32'd0);
    rst = 1'b0;

    // First run right after reset release (nominal input on the datapath side).
    wait_cycles(1);
    start_run();
    wait_cycles(30);
    chk("done_cnt_run1", done_cnt, 1);

    // Second run (zero input on the datapath side).
    start_run();
    wait_cycles(30);
    chk("done_cnt_run2", done_cnt, 2);

    // Start pulsed again mid-run must be ignored.
    start_run();
    wait_cycles(8);
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(25);
    chk("done_cnt_busy_start", done_cnt, 3);

    // Start held high: DONE -> IDLE -> INIT back-to-back.
    @(negedge clk);
    #1;
    start = 1'b1;
    push_run();
    exp_q.push_back(14'h0);
    push_run();
    wait_cycles(30);
    start = 1'b0;
    wait_cycles(30);
    chk("done_cnt_held", done_cnt, 5);

    // Reset mid-run: outputs drop at once, no done pulse.
    start_run();
    wait_cycles(10);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_mid_outs", 32'(obs_word()), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(30);
    chk("done_cnt_after_rst", done_cnt, 5);

    // Fresh run after the abort completes normally.
    start_run();
    wait_cycles(30);
    chk("done_cnt_final", done_cnt, 6);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
